mc8051_mem_resp: RTL and testbench



---
 rtl/mc8051_mem_resp.sv | 151 +++++++++++++++
 tb/tb_mc8051_mem_resp.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mc8051_mem_resp.sv
// mc8051_mem_resp: memory-side responder for the mc8051 core.
// Owns internal RAM, decodes direct addresses into IRAM or the SFR bus, and
// forwards XRAM/CODE accesses to the external bus with minimum wait states.
// Optional feature macro: MC8051_IRAM_UPPER_EN (256-byte IRAM when defined,
// 128-byte IRAM otherwise).
module mc8051_mem_resp #(
    parameter int XRAM_WAIT = 2,
    parameter int CODE_WAIT = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [1:0]  i_space,
    input  logic [15:0] i_addr,
    input  logic [7:0]  i_wdata,
    output logic        o_busy,
    output logic        o_rvalid,
    output logic [7:0]  o_rdata,
    output logic        o_err,
    output logic        o_sfr_re,
    output logic        o_sfr_we,
    output logic [7:0]  o_sfr_addr,
    output logic [7:0]  o_sfr_wdata,
    input  logic [7:0]  i_sfr_rdata,
    output logic        o_xbus_req,
    output logic        o_xbus_we,
    output logic        o_xbus_code,
    output logic [15:0] o_xbus_addr,
    output logic [7:0]  o_xbus_wdata,
    input  logic        i_xbus_ready,
    input  logic [7:0]  i_xbus_rdata
);

`ifdef MC8051_IRAM_UPPER_EN
    localparam int IRAM_AW = 8;
`else
    localparam int IRAM_AW = 7;
`endif
    localparam int IRAM_DEPTH = 1 << IRAM_AW;

    localparam logic [3:0] XW = XRAM_WAIT[3:0];
    localparam logic [3:0] CW = CODE_WAIT[3:0];

    typedef enum logic {IDLE, XWAIT} state_t;

    state_t state, state_nxt;

    logic [7:0]         iram [IRAM_DEPTH];
    logic [3:0]         cnt;
    logic [IRAM_AW-1:0] iram_idx;
    logic               accept;
    logic               is_ext;
    logic               is_sfr;
    logic               in_range;
    logic               iram_hit;
    logic               code_wr;
    logic               ext_start;
    logic               done;

    // Only indirect accesses can reach IRAM with addr[7]=1; without the upper
    // bank those fall outside the array (reads give 0xFF, writes vanish).
`ifdef MC8051_IRAM_UPPER_EN
    assign in_range = 1'b1;
`else
    assign in_range = ~i_addr[7];
`endif

    assign iram_idx  = i_addr[IRAM_AW-1:0];
    assign accept    = i_req & ~o_busy;
    assign is_ext    = i_space[1];
    assign is_sfr    = (i_space == 2'b00) & i_addr[7];
    assign iram_hit  = ~is_ext & ~is_sfr & in_range;
    assign code_wr   = is_ext & i_space[0] & i_we;
    assign ext_start = accept & is_ext & ~code_wr;
    assign done      = (state == XWAIT) && (cnt == 4'd0) && i_xbus_ready;

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // FSM next state: IDLE until an external access starts, XWAIT until done
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ext_start) state_nxt = XWAIT;
            XWAIT:   if (done)      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: busy flag and combinational SFR strobes in the accept cycle
    always_comb begin
        o_busy      = (state == XWAIT);
        o_sfr_re    = accept & is_sfr & ~i_we;
        o_sfr_we    = accept & is_sfr & i_we;
        o_sfr_addr  = (accept & is_sfr) ? i_addr[7:0] : 8'h00;
        o_sfr_wdata = (accept & is_sfr & i_we) ? i_wdata : 8'h00;
    end

    // IRAM array: writes commit at the accept edge; contents survive reset
    always_ff @(posedge i_clk) begin
        if (accept && iram_hit && i_we) iram[iram_idx] <= i_wdata;
    end

    // Datapath: read return, error pulse, wait counter and external bus regs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rvalid     <= 1'b0;
            o_rdata      <= 8'h00;
            o_err        <= 1'b0;
            cnt          <= 4'd0;
            o_xbus_req   <= 1'b0;
            o_xbus_we    <= 1'b0;
            o_xbus_code  <= 1'b0;
            o_xbus_addr  <= 16'h0000;
            o_xbus_wdata <= 8'h00;
        end else begin
            o_rvalid <= 1'b0;
            o_err    <= 1'b0;
            if (accept && !is_ext && !i_we) begin
                o_rvalid <= 1'b1;
                if (is_sfr)        o_rdata <= i_sfr_rdata;
                else if (iram_hit) o_rdata <= iram[iram_idx];
                else               o_rdata <= 8'hFF;
            end
            if (accept && code_wr) o_err <= 1'b1;
            if (ext_start) begin
                cnt          <= i_space[0] ? CW : XW;
                o_xbus_req   <= 1'b1;
                o_xbus_we    <= i_we;
                o_xbus_code  <= i_space[0];
                o_xbus_addr  <= i_addr;
                o_xbus_wdata <= i_wdata;
            end else if (state == XWAIT) begin
                // counter saturates at zero while waiting on i_xbus_ready
                if (cnt != 4'd0) cnt <= cnt - 4'd1;
                if (done) begin
                    o_xbus_req <= 1'b0;
                    if (!o_xbus_we) begin
                        o_rvalid <= 1'b1;
                        o_rdata  <= i_xbus_rdata;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mc8051_mem_resp.sv
// Bench for mc8051_mem_resp: transaction-level reference model (deadline
// arithmetic for external accesses, plain byte array for IRAM), a per-cycle
// compare process, and directed vectors with literal expectations.
module tb_mc8051_mem_resp;
    localparam int XW = 2;
    localparam int CW = 1;
`ifdef MC8051_IRAM_UPPER_EN
    localparam bit UPPER = 1'b1;
`else
    localparam bit UPPER = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req = 1'b0, we = 1'b0;
    logic [1:0]  space = 2'b00;
    logic [15:0] addr = 16'h0;
    logic [7:0]  wdata = 8'h0, sfr_rdata = 8'h0, xrdata = 8'h0;
    logic        xready = 1'b1;

    logic        busy, rvalid, err, sfr_re, sfr_we, xreq, xwe, xcode;
    logic [7:0]  rdata, sfr_addr, sfr_wdata, xwdata;
    logic [15:0] xaddr;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    bit chk_on = 1'b0;

    mc8051_mem_resp #(.XRAM_WAIT(XW), .CODE_WAIT(CW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_we(we), .i_space(space),
        .i_addr(addr), .i_wdata(wdata), .o_busy(busy), .o_rvalid(rvalid),
        .o_rdata(rdata), .o_err(err), .o_sfr_re(sfr_re), .o_sfr_we(sfr_we),
        .o_sfr_addr(sfr_addr), .o_sfr_wdata(sfr_wdata), .i_sfr_rdata(sfr_rdata),
        .o_xbus_req(xreq), .o_xbus_we(xwe), .o_xbus_code(xcode),
        .o_xbus_addr(xaddr), .o_xbus_wdata(xwdata), .i_xbus_ready(xready),
        .i_xbus_rdata(xrdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, a, e, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  mem [256];
    logic        m_busy = 0, m_xreq = 0, m_rvalid = 0, m_err = 0, m_xwe = 0, m_xcode = 0;
    logic [7:0]  m_rdata = 0, m_xwdata = 0;
    logic [15:0] m_xaddr = 0;
    int          m_deadline = 0;

    // An external access accepted at edge N may finish at the first edge
    // >= N+1+WAIT that sees ready; everything else resolves at the accept edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 0; m_xreq <= 0; m_rvalid <= 0; m_err <= 0;
            m_xwe <= 0; m_xcode <= 0; m_rdata <= 0; m_xwdata <= 0; m_xaddr <= 0;
        end else begin
            m_rvalid <= 0;
            m_err    <= 0;
            if (m_busy) begin
                if (cyc >= m_deadline && xready) begin
                    m_busy <= 0;
                    m_xreq <= 0;
                    if (!m_xwe) begin m_rvalid <= 1; m_rdata <= xrdata; end
                end
            end else if (req) begin
                if (space[1]) begin
                    if (space[0] && we) m_err <= 1;
                    else begin
                        m_busy <= 1; m_xreq <= 1; m_xwe <= we; m_xcode <= space[0];
                        m_xaddr <= addr; m_xwdata <= wdata;
                        m_deadline <= cyc + 1 + (space[0] ? CW : XW);
                    end
                end else if (space == 2'b00 && addr[7]) begin
                    if (!we) begin m_rvalid <= 1; m_rdata <= sfr_rdata; end
                end else if (addr[7] && !UPPER) begin
                    if (!we) begin m_rvalid <= 1; m_rdata <= 8'hFF; end
                end else begin
                    if (we) mem[addr[7:0]] <= wdata;
                    else begin m_rvalid <= 1; m_rdata <= mem[addr[7:0]]; end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_on) begin
            logic e_sfr;
            e_sfr = req && !m_busy && space == 2'b00 && addr[7];
            chk("busy", busy, m_busy);
            chk("xbus_req", xreq, m_xreq);
            chk("rvalid", rvalid, m_rvalid);
            chk("err", err, m_err);
            chk("sfr_re", sfr_re, e_sfr && !we);
            chk("sfr_we", sfr_we, e_sfr && we);
            chk("xbus_we", xwe, m_xwe);
            chk("xbus_code", xcode, m_xcode);
            chk("xbus_addr", xaddr, m_xaddr);
            chk("xbus_wdata", xwdata, m_xwdata);
            if (m_rvalid) chk("rdata", rdata, m_rdata);
            if (e_sfr) chk("sfr_addr", sfr_addr, addr[7:0]);
            if (e_sfr && we) chk("sfr_wdata", sfr_wdata, wdata);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue(input logic [1:0] sp, input logic w, input logic [15:0] a,
                         input logic [7:0] d);
        req = 1'b1; we = w; space = sp; addr = a; wdata = d;
        @(posedge clk); #1;
        req = 1'b0; we = 1'b0;
    endtask

    task automatic wait_rv(input string nm, output int c);
        bit seen;
        seen = 0;
        c = 0;
        for (int n = 0; n < 60 && !seen; n++) begin
            @(negedge clk);
            if (rvalid) begin seen = 1; c = cyc; end
        end
        if (!seen) chk({nm, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_idle(input string nm);
        bit idle;
        idle = 0;
        for (int n = 0; n < 60 && !idle; n++) begin
            @(negedge clk);
            if (!busy) idle = 1;
        end
        if (!idle) chk({nm, "_timeout"}, 32'd0, 32'd1);
    endtask

    // ---------------- directed vectors ----------------
    initial begin
        int acc, rv;
        #2 rst_n = 1'b0;
        chk_on = 1'b1;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_xaddr", xaddr, 0);
        chk("rst_xreq", xreq, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // IRAM direct write then read back, one request per cycle
        issue(2'b00, 1, 16'h0030, 8'h5A);
        issue(2'b01, 1, 16'h0010, 8'h11);
        issue(2'b00, 0, 16'h0030, 8'h00);
        acc = cyc;
        wait_rv("iram_rd", rv);
        chk("iram_lat", rv - acc, 0);
        chk("iram_val", rdata, 8'h5A);
        issue(2'b00, 0, 16'h0010, 8'h00);
        wait_rv("iram_rd2", rv);
        chk("iram_val2", rdata, 8'h11);

        // SFR read and write
        sfr_rdata = 8'h3C;
        req = 1'b1; we = 1'b0; space = 2'b00; addr = 16'h00E0;
        @(negedge clk);
        chk("sfr_re_lit", sfr_re, 1);
        chk("sfr_addr_lit", sfr_addr, 8'hE0);
        @(posedge clk); #1 req = 1'b0;
        wait_rv("sfr_rd", rv);
        chk("sfr_val", rdata, 8'h3C);
        issue(2'b00, 1, 16'h0081, 8'h07);

        // XRAM read, ready high; a request during busy must be dropped
        xready = 1'b1; xrdata = 8'h77;
        issue(2'b10, 0, 16'h1234, 8'h00);
        acc = cyc;
        issue(2'b00, 0, 16'h0030, 8'h00);
        wait_rv("xram_rd", rv);
        chk("xram_lat", rv - acc, 3);
        chk("xram_val", rdata, 8'h77);
        chk("xram_addr", xaddr, 16'h1234);
        @(negedge clk);
        chk("no_second_rv", rvalid, 0);

        // XRAM read with ready held low 4 cycles past the earliest completion
        xready = 1'b0; xrdata = 8'hC3;
        issue(2'b10, 0, 16'h0456, 8'h00);
        acc = cyc;
        repeat (6) @(posedge clk);
        #1 xready = 1'b1;
        wait_rv("xram_slow", rv);
        chk("xram_slow_lat", rv - acc, 7);
        chk("xram_slow_val", rdata, 8'hC3);

        // XRAM write, CODE read
        issue(2'b10, 1, 16'h2000, 8'hAB);
        wait_idle("xram_wr");
        xrdata = 8'h02;
        issue(2'b11, 0, 16'h0100, 8'h00);
        acc = cyc;
        wait_rv("code_rd", rv);
        chk("code_lat", rv - acc, 2);
        chk("code_val", rdata, 8'h02);

        // CODE write: error pulse, no bus activity, IRAM untouched
        issue(2'b11, 1, 16'h0030, 8'hEE);
        @(negedge clk);
        chk("code_wr_err", err, 1);
        chk("code_wr_xreq", xreq, 0);
        issue(2'b00, 0, 16'h0030, 8'h00);
        wait_rv("iram_after_code", rv);
        chk("iram_after_code", rdata, 8'h5A);

        // Indirect upper range
        issue(2'b01, 1, 16'h0090, 8'hA5);
        issue(2'b01, 0, 16'h0090, 8'h00);
        wait_rv("ind_hi", rv);
        chk("ind_hi_val", rdata, UPPER ? 8'hA5 : 8'hFF);

        // Reset in the middle of an external wait
        xready = 1'b0;
        issue(2'b10, 0, 16'h0F00, 8'h00);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_xreq", xreq, 0);
        chk("rst_mid_rvalid", rvalid, 0);
        #2 rst_n = 1'b1;
        xready = 1'b1;
        issue(2'b00, 0, 16'h0030, 8'h00);
        wait_rv("post_rst", rv);
        chk("post_rst_val", rdata, 8'h5A);

        repeat (3) @(posedge clk);
        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
